// File: rtl/icache_direct.sv
// Direct-mapped instruction cache between the fetcher and the memory controller.
// Hits answer one cycle after the request; misses fill a whole line word by word, then answer.
module icache_direct #(
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_pc_sgn,
    input  logic [31:0] IF_pc,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_ins_sgn,
    input  logic [31:0] MC_ins,
    input  logic        ROB_jp_wrong
);
    localparam int unsigned LINES   = 1 << INDEX_W;
    localparam int unsigned WORDS   = 1 << OFFSET_W;
    localparam int unsigned TAG_W   = 30 - INDEX_W - OFFSET_W;
    localparam int unsigned TAG_LSB = OFFSET_W + INDEX_W + 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]          state, state_n;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];
    logic                drop, drop_n;
    logic [OFFSET_W-1:0] want, want_n;
    logic                ins_sgn_n;
    logic [31:0]         ins_n;
    logic                req_n;
    logic [31:0]         addr_n;

    logic [INDEX_W-1:0]  pc_idx, fill_idx;
    logic [OFFSET_W-1:0] pc_off, fill_off;
    logic [TAG_W-1:0]    pc_tag, fill_tag;
    logic                hit, fill_we, fill_last;
    logic [1:0]          unused_byte;

    // The fill word counter is the low bits of MC_addr itself.
    assign pc_idx      = IF_pc[TAG_LSB-1 -: INDEX_W];
    assign pc_off      = IF_pc[OFFSET_W+1 -: OFFSET_W];
    assign pc_tag      = IF_pc[31 -: TAG_W];
    assign fill_idx    = MC_addr[TAG_LSB-1 -: INDEX_W];
    assign fill_off    = MC_addr[OFFSET_W+1 -: OFFSET_W];
    assign fill_tag    = MC_addr[31 -: TAG_W];
    assign hit         = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign fill_we     = (state == FILL) && MC_ins_sgn;
    assign fill_last   = &fill_off;
    assign unused_byte = IF_pc[1:0];

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        drop_n    = drop;
        want_n    = want;
        ins_sgn_n = 1'b0;
        ins_n     = IF_ins;
        req_n     = MC_req;
        addr_n    = MC_addr;
        case (state)
            IDLE: begin
                if (!ROB_jp_wrong && IF_pc_sgn) begin
                    if (hit) begin
                        ins_sgn_n = 1'b1;
                        ins_n     = data_mem[{pc_idx, pc_off}];
                    end else begin
                        state_n = FILL;
                        req_n   = 1'b1;
                        addr_n  = {IF_pc[31:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
                        want_n  = pc_off;
                        drop_n  = 1'b0;
                    end
                end
            end
            FILL: begin
                if (ROB_jp_wrong) drop_n = 1'b1;
                if (MC_ins_sgn) begin
                    if (fill_off == want) ins_n = MC_ins;
                    if (fill_last) begin
                        state_n   = IDLE;
                        req_n     = 1'b0;
                        drop_n    = 1'b0;
                        ins_sgn_n = !(drop || ROB_jp_wrong);
                    end else begin
                        addr_n = MC_addr + 32'd4;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control and output registers; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            drop       <= 1'b0;
            want       <= '0;
            IF_ins_sgn <= 1'b0;
            IF_ins     <= '0;
            MC_req     <= 1'b0;
            MC_addr    <= '0;
        end else if (rdy) begin
            state      <= state_n;
            drop       <= drop_n;
            want       <= want_n;
            IF_ins_sgn <= ins_sgn_n;
            IF_ins     <= ins_n;
            MC_req     <= req_n;
            MC_addr    <= addr_n;
            if (fill_we && fill_last) valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; validity lives in the valid bits.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_we) begin
            data_mem[{fill_idx, fill_off}] <= MC_ins;
            if (fill_last) tag_mem[fill_idx] <= fill_tag;
        end
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache; the responder end of the fetch-request interface (fetcher sends pc/valid, cache returns instruction/valid).
- Hits answer one cycle after the request. Misses fill a whole line, one word per memory-controller response, then answer.
- Sits between the instruction fetcher and the memory controller. Honours misprediction flush and the global rdy stall.

Parameters:
- INDEX_W, 6, log2 of line count (64 lines).
- OFFSET_W, 2, log2 of words per line (4 words = 16 B). Tag width = 30 - INDEX_W - OFFSET_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low = freeze
- IF_pc_sgn  in  1  fetch request valid (level; may stay high every cycle)
- IF_pc  in  32  fetch address; bits [1:0] ignored
- IF_ins_sgn  out  1  instruction valid pulse (registered)
- IF_ins  out  32  instruction for the last accepted pc
- MC_req  out  1  word-read request to memory controller (registered, level)
- MC_addr  out  32  word address, word-aligned; stable while MC_req high
- MC_ins_sgn  in  1  memory word valid pulse
- MC_ins  in  32  memory word
- ROB_jp_wrong  in  1  misprediction flush

Behaviour:
- Reset (clk edge with rst=1):
  - All valid bits cleared; state IDLE.
  - IF_ins_sgn=0, IF_ins=0, MC_req=0, MC_addr=0; drop flag cleared.
  - Reset mid-fill abandons the fill; the memory controller is reset concurrently.
- rdy=0: no state, array or output register changes. Every cycle rule below counts rdy=1 edges only.
- States: IDLE, FILL.
- IDLE, IF_pc_sgn=1, hit (valid and tag match): next edge sets IF_ins_sgn=1 and IF_ins=data. Back-to-back hits give 1 instr/cycle, because the fetcher updates IF_pc in the response cycle.
- IDLE, IF_pc_sgn=0: next edge sets IF_ins_sgn=0.
- IDLE, miss:
  - Latch miss pc; go to FILL.
  - MC_req=1; MC_addr = line base (pc with offset and byte bits zeroed).
  - IF_ins_sgn=0.
- FILL:
  - Keep MC_req/MC_addr stable until MC_ins_sgn=1.
  - On each MC_ins_sgn, write MC_ins to word k of the line. If k equals the requested word, capture it into the response register.
  - After a non-final word, MC_addr += 4 on the next edge and MC_req stays 1.
  - On the final word (k = 2^OFFSET_W - 1): write tag, set valid, MC_req=0, return to IDLE.
  - If the drop flag is clear, IF_ins_sgn=1 on the same edge with the requested word.
- MC contract: at most one outstanding word request. MC_ins_sgn is never asserted while MC_req=0. Words always return in order from word 0.
- ROB_jp_wrong=1:
  - Next edge forces IF_ins_sgn=0 (discard).
  - In IDLE, IF_pc that cycle is the redirect target and is looked up normally (hit: response on the next-but-one edge? no — hit response follows the standard 1-cycle rule from the cycle after flush is processed). To keep this exact: a flush cycle's own lookup is suppressed; lookup resumes the following cycle.
  - In FILL: set the drop flag. The fill runs to completion (MC requests are not abortable) and the line becomes valid. No IF response is issued; return to IDLE; the drop flag clears.
- Simultaneous final MC_ins_sgn and ROB_jp_wrong: line written valid, no IF response.
- IF_pc_sgn is ignored while in FILL. The fetcher holds its pc until a response arrives.
- Index = IF_pc[OFFSET_W+INDEX_W+1 : OFFSET_W+2]; word offset = IF_pc[OFFSET_W+1:2].

Test Plan:
- Cold miss: reset, IF_pc=0x0 held; MC answers 3 cycles after each request with word = addr^0xA5A5.
  - Required: MC_addr 0x0, 0x4, 0x8, 0xC in order.
  - IF_ins_sgn=1 with IF_ins=0x0000A5A5 on the edge of the 4th MC_ins_sgn; MC_req=0 afterwards.
- Hits after fill: IF_pc 0x4, then 0x8, then 0xC on consecutive cycles.
  - Required: three consecutive IF_ins_sgn pulses with 0xA5A1, 0xA5AD, 0xA5A9; MC_req never rises.
- Conflict: after filling 0x0, fetch 0x400, then 0x0.
  - Required: both miss (two full 4-word fills); the second returns 0xA5A5 again.
- Flush during fill: miss at 0x20; assert ROB_jp_wrong while word 1 is pending.
  - Required: fill completes at 0x20..0x2C with no IF_ins_sgn.
  - A subsequent fetch of 0x24 hits with a 1-cycle response.
- rdy stall: hold rdy=0 for 5 cycles mid-fill, then also hold it low in the cycle a hit response is high.
  - Required: MC_req/MC_addr unchanged during the stall; IF_ins_sgn stays high until the next rdy=1 edge, then clears.
- Reset mid-fill: assert rst while in FILL after 2 words.
  - Required: MC_req=0, IF_ins_sgn=0; fetching 0x0 afterwards misses (valid bits cleared).
